vga_fb_arbiter: RTL and testbench
=================================

// Module: vga_fb_arbiter
// PURPOSE
//  Shares the single-port VGA frame buffer between the display scan-out fetch and the frame-buffer writers.
//  Requesters: the display path (strict priority, never stalled), a hardware frame-clear sequencer, and two
//  pixel writers (round-robin). Sits between the VGA timing/scan-out logic and the frame-buffer RAM.
// PARAMETERS
//  data_width  3    pixel colour bits
//  addr_width  19   frame-buffer address bits
//  horiz       640  active pixels per line
//  vert        480  active lines per frame; FB_SIZE = horiz*vert (307200)
// PORTS
//  clk          in   1           system clock, all logic rising-edge
//  rst          in   1           synchronous reset, active-high
//  disp_req     in   1           display fetch request, served in the same cycle it is sampled
//  disp_addr    in   addr_width  display fetch address
//  disp_rvalid  out  1           disp_rdata valid (pulse)
//  disp_rdata   out  data_width  fetched pixel
//  w0_valid     in   1           writer 0 request
//  w0_addr      in   addr_width  writer 0 address
//  w0_data      in   data_width  writer 0 pixel
//  w0_ready     out  1           writer 0 accepted (combinational)
//  w1_valid/w1_addr/w1_data/w1_ready   as writer 0
//  clr_start    in   1           pulse: fill whole buffer with clr_color
//  clr_color    in   data_width  fill colour, captured on clr_start
//  clr_busy     out  1           clear in progress
//  clr_done     out  1           one-cycle pulse after last clear write issued
//  wr_err       out  1           sticky: writer address >= FB_SIZE was dropped; cleared by rst only
//  mem_en       out  1           RAM enable
//  mem_we       out  1           RAM write enable
//  mem_addr     out  addr_width  RAM address
//  mem_wdata    out  data_width  RAM write data
//  mem_rdata    in   data_width  RAM read data, 1-cycle latency after mem_en&!mem_we
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; rr pointer=writer 0; clear counter=0; wr_err=0.
//  Priority per cycle N: disp_req > clear slot (state CLEAR) > writers (round-robin).
//  mem_en/we/addr/wdata registered: winner of cycle N drives RAM in cycle N+1; no winner -> mem_en=0.
//  Display: read issued N+1; disp_rvalid=1 in N+2 with disp_rdata=mem_rdata. Reads back-to-back every cycle.
//  Writers: wK_ready=1 only when wK is granted in cycle N; transfer = valid&ready. ready never asserted
//   while disp_req=1 or FSM=CLEAR. Writers must hold valid/addr/data until ready.
//  Round-robin: both valid -> grant the writer indicated by rr; after any writer transfer rr points to the
//   other writer. Single valid writer granted regardless of rr. rr unchanged on cycles with no transfer.
//  Address range: writer transfer with addr >= FB_SIZE: ready still asserted (handshake completes),
//   no RAM write (mem_en=0 in N+1), wr_err set. Display addresses not checked.
//  FSM: IDLE --clr_start--> CLEAR (capture clr_color, counter=0, clr_busy=1 from next cycle).
//   CLEAR: each cycle with disp_req=0 issues write(counter, colour) and counter+1; disp_req=1 stalls counter.
//   Write of counter=FB_SIZE-1 -> DONE; DONE: clr_done=1 for one cycle, clr_busy=0 -> IDLE.
//   clr_start in CLEAR/DONE ignored. Counter never exceeds FB_SIZE-1 (no wrap).
//  rst in any state (mid-clear included) aborts: no further clear writes, state/counter/rr return to reset.
//  Simultaneous disp_req and clr_start in IDLE: display served, clear entered next cycle.
// TESTING
//  1) rst; disp_req 1 for 4 cycles, addr 0..3 -> mem_en=1,we=0 addr 0..3 at N+1; disp_rvalid 4 cycles at N+2.
//  2) w0_valid,w1_valid held, no disp -> ready alternates w0,w1,w0,w1; mem writes alternate in same order.
//  3) disp_req continuous 10 cycles with w0_valid=1 -> w0_ready=0 throughout, granted on first idle cycle.
//  4) w1_addr=307200 -> w1_ready=1, no RAM write, wr_err=1 and stays 1 until rst.
//  5) clr_start colour 3'b101, disp_req 50% -> 307200 writes addr 0..307199 data 5, one clr_done, writers blocked.
//  6) rst asserted mid-clear at counter 1000 -> mem_en=0 next cycle, clr_busy=0, clr_done never pulses.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - frame-buffer port arbiter: display fetch, clear sequencer, two round-robin writers
module vga_fb_arbiter #(
  parameter int data_width = 3,
  parameter int addr_width = 19,
  parameter int horiz      = 640,
  parameter int vert       = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  disp_req_i,
  input  logic [addr_width-1:0] disp_addr_i,
  output logic                  disp_rvalid_o,
  output logic [data_width-1:0] disp_rdata_o,
  input  logic                  w0_valid_i,
  input  logic [addr_width-1:0] w0_addr_i,
  input  logic [data_width-1:0] w0_data_i,
  output logic                  w0_ready_o,
  input  logic                  w1_valid_i,
  input  logic [addr_width-1:0] w1_addr_i,
  input  logic [data_width-1:0] w1_data_i,
  output logic                  w1_ready_o,
  input  logic                  clr_start_i,
  input  logic [data_width-1:0] clr_color_i,
  output logic                  clr_busy_o,
  output logic                  clr_done_o,
  output logic                  wr_err_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [addr_width-1:0] mem_addr_o,
  output logic [data_width-1:0] mem_wdata_o,
  input  logic [data_width-1:0] mem_rdata_i
);

  localparam int unsigned FB_SIZE = horiz * vert;
  localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(FB_SIZE - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t                  state_q;
  logic [addr_width-1:0]   cnt_q;
  logic [data_width-1:0]   color_q;
  logic                    rr_q;
  logic                    clr_busy_q, clr_done_q, wr_err_q;
  logic                    disp_p1_q, disp_rvalid_q;
  logic                    mem_en_q, mem_we_q;
  logic [addr_width-1:0]   mem_addr_q;
  logic [data_width-1:0]   mem_wdata_q;

  logic                    mem_en_d, mem_we_d;
  logic [addr_width-1:0]   mem_addr_d;
  logic [data_width-1:0]   mem_wdata_d;
  logic                    writer_slot, clr_slot, gnt0, gnt1, in_range0, in_range1;

  always_comb begin
    writer_slot = !disp_req_i && (state_q != CLEAR);
    clr_slot    = !disp_req_i && (state_q == CLEAR);
    // rr_q names the writer that wins a tie; a lone requester wins regardless
    gnt0        = writer_slot && w0_valid_i && (!w1_valid_i || !rr_q);
    gnt1        = writer_slot && w1_valid_i && (!w0_valid_i ||  rr_q);
    in_range0   = 32'(w0_addr_i) < FB_SIZE;
    in_range1   = 32'(w1_addr_i) < FB_SIZE;

    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (disp_req_i) begin
      mem_en_d   = 1'b1;
      mem_addr_d = disp_addr_i;
    end else if (clr_slot) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = cnt_q;
      mem_wdata_d = color_q;
    end else if (gnt0 && in_range0) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = w0_addr_i;
      mem_wdata_d = w0_data_i;
    end else if (gnt1 && in_range1) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = w1_addr_i;
      mem_wdata_d = w1_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      color_q       <= '0;
      rr_q          <= 1'b0;
      clr_busy_q    <= 1'b0;
      clr_done_q    <= 1'b0;
      wr_err_q      <= 1'b0;
      disp_p1_q     <= 1'b0;
      disp_rvalid_q <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      disp_p1_q     <= disp_req_i;
      disp_rvalid_q <= disp_p1_q;
      if (gnt0 || gnt1) rr_q <= gnt0;
      wr_err_q <= wr_err_q | (gnt0 && !in_range0) | (gnt1 && !in_range1);

      case (state_q)
        IDLE: begin
          clr_done_q <= 1'b0;
          if (clr_start_i) begin
            state_q    <= CLEAR;
            color_q    <= clr_color_i;
            cnt_q      <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        CLEAR: begin
          if (!disp_req_i) begin
            if (cnt_q == LAST_ADDR) begin
              state_q    <= DONE;
              clr_busy_q <= 1'b0;
              clr_done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + addr_width'(1);
            end
          end
        end
        DONE: begin
          clr_done_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign w0_ready_o    = gnt0;
  assign w1_ready_o    = gnt1;
  assign disp_rvalid_o = disp_rvalid_q;
  // read data arrives from the RAM in the rvalid cycle; held at zero otherwise
  assign disp_rdata_o  = disp_rvalid_q ? mem_rdata_i : '0;
  assign clr_busy_o    = clr_busy_q;
  assign clr_done_o    = clr_done_q;
  assign wr_err_o      = wr_err_q;
  assign mem_en_o      = mem_en_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - directed bench: full-size arbiter plus a 32-pixel instance for a complete clear
module tb_vga_fb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        disp_req;
  logic [18:0] disp_addr;
  logic        w0_valid, w1_valid, clr_start;
  logic [18:0] w0_addr, w1_addr;
  logic [2:0]  w0_data, w1_data, clr_color;
  logic [2:0]  mem_rdata = 3'd0, mem_rdata_s = 3'd0;

  logic        disp_rvalid, w0_ready, w1_ready, clr_busy, clr_done, wr_err, mem_en, mem_we;
  logic [2:0]  disp_rdata, mem_wdata;
  logic [18:0] mem_addr;
  logic        disp_rvalid_s, w0_ready_s, w1_ready_s, clr_busy_s, clr_done_s, wr_err_s, mem_en_s, mem_we_s;
  logic [2:0]  disp_rdata_s, mem_wdata_s;
  logic [18:0] mem_addr_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // RAM stand-ins: read data is a fixed function of the address, one cycle late
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= mem_addr[2:0] ^ 3'b101;
    if (mem_en_s && !mem_we_s) mem_rdata_s <= mem_addr_s[2:0] ^ 3'b101;
  end

  vga_fb_arbiter dut (
    .clk(clk), .rst(rst), .disp_req_i(disp_req), .disp_addr_i(disp_addr),
    .disp_rvalid_o(disp_rvalid), .disp_rdata_o(disp_rdata),
    .w0_valid_i(w0_valid), .w0_addr_i(w0_addr), .w0_data_i(w0_data), .w0_ready_o(w0_ready),
    .w1_valid_i(w1_valid), .w1_addr_i(w1_addr), .w1_data_i(w1_data), .w1_ready_o(w1_ready),
    .clr_start_i(clr_start), .clr_color_i(clr_color), .clr_busy_o(clr_busy), .clr_done_o(clr_done),
    .wr_err_o(wr_err), .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata));

  vga_fb_arbiter #(.horiz(8), .vert(4)) dut_s (
    .clk(clk), .rst(rst), .disp_req_i(disp_req), .disp_addr_i(disp_addr),
    .disp_rvalid_o(disp_rvalid_s), .disp_rdata_o(disp_rdata_s),
    .w0_valid_i(w0_valid), .w0_addr_i(w0_addr), .w0_data_i(w0_data), .w0_ready_o(w0_ready_s),
    .w1_valid_i(w1_valid), .w1_addr_i(w1_addr), .w1_data_i(w1_data), .w1_ready_o(w1_ready_s),
    .clr_start_i(clr_start), .clr_color_i(clr_color), .clr_busy_o(clr_busy_s), .clr_done_o(clr_done_s),
    .wr_err_o(wr_err_s), .mem_en_o(mem_en_s), .mem_we_o(mem_we_s), .mem_addr_o(mem_addr_s),
    .mem_wdata_o(mem_wdata_s), .mem_rdata_i(mem_rdata_s));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int writes, bad, viol, extra, exp_cnt;
    logic done_seen;
    rst = 1'b1; disp_req = 0; disp_addr = '0; clr_start = 0; clr_color = '0;
    w0_valid = 0; w1_valid = 0; w0_addr = '0; w1_addr = '0; w0_data = '0; w1_data = '0;
    #1;
    step();
    step();
    @(negedge clk);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_rvalid", disp_rvalid, 0);
    chk("rst_busy", clr_busy, 0);
    chk("rst_wr_err", wr_err, 0);
    rst = 1'b0;
    step();

    // 1) four back-to-back display reads
    for (int i = 0; i < 6; i++) begin
      logic [2:0] exp_rd;
      disp_req  = (i < 4);
      disp_addr = 19'(i);
      exp_rd    = 3'(i - 2) ^ 3'b101;
      @(negedge clk);
      chk("t1_mem_en", mem_en, (i >= 1 && i <= 4));
      if (i >= 1 && i <= 4) begin
        chk("t1_mem_we", mem_we, 0);
        chk("t1_mem_addr", mem_addr, i - 1);
      end
      chk("t1_rvalid", disp_rvalid, (i >= 2));
      if (i >= 2) chk("t1_rdata", disp_rdata, exp_rd);
      step();
    end
    disp_req = 0;

    // 2) both writers held valid: strict alternation starting at writer 0
    w0_valid = 1; w0_addr = 19'd10; w0_data = 3'd1;
    w1_valid = 1; w1_addr = 19'd20; w1_data = 3'd2;
    for (int j = 0; j < 5; j++) begin
      if (j == 4) begin w0_valid = 0; w1_valid = 0; end
      @(negedge clk);
      if (j < 4) begin
        chk("t2_w0_ready", w0_ready, (j % 2 == 0));
        chk("t2_w1_ready", w1_ready, (j % 2 == 1));
      end
      if (j > 0) begin
        chk("t2_mem_we", mem_we, 1);
        chk("t2_mem_addr", mem_addr, ((j - 1) % 2 == 0) ? 10 : 20);
        chk("t2_mem_wdata", mem_wdata, ((j - 1) % 2 == 0) ? 1 : 2);
      end
      step();
    end

    // 3) display hogs the port for ten cycles; writer 0 waits then wins
    disp_req = 1; w0_valid = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t3_w0_blocked", w0_ready, 0);
      step();
    end
    disp_req = 0;
    @(negedge clk);
    chk("t3_w0_granted", w0_ready, 1);
    step();
    w0_valid = 0;
    @(negedge clk);
    chk("t3_mem_we", mem_we, 1);
    chk("t3_mem_addr", mem_addr, 10);
    step();

    // 4) out-of-range write: handshake completes, nothing reaches RAM, sticky error
    w1_valid = 1; w1_addr = 19'd307200;
    @(negedge clk);
    chk("t4_w1_ready", w1_ready, 1);
    step();
    w1_valid = 0; w1_addr = 19'd20;
    @(negedge clk);
    chk("t4_mem_en", mem_en, 0);
    chk("t4_wr_err", wr_err, 1);
    step(); step(); step();
    @(negedge clk);
    chk("t4_wr_err_sticky", wr_err, 1);

    // 5) full clear of the 32-pixel instance with 50% display load and writer 0 pending
    do_reset();
    @(negedge clk);
    chk("t5_wr_err_after_rst", wr_err, 0);
    clr_start = 1; clr_color = 3'b101; disp_req = 1; disp_addr = 19'd7;
    w0_valid = 1; w0_addr = 19'd3; w0_data = 3'd6;
    @(negedge clk);
    chk("t5_w0_blocked_start", w0_ready_s, 0);
    step();
    clr_start = 0;
    writes = 0; bad = 0; viol = 0; exp_cnt = 0; done_seen = 0;
    for (int n = 0; n < 200 && !done_seen; n++) begin
      disp_req = n[0];
      @(negedge clk);
      if (n == 0) begin
        chk("t5_disp_first_en", mem_en_s, 1);
        chk("t5_disp_first_we", mem_we_s, 0);
        chk("t5_busy", clr_busy_s, 1);
      end
      if (clr_busy_s && w0_ready_s) viol++;
      if (mem_en_s && mem_we_s) begin
        if (mem_addr_s != 19'(exp_cnt) || mem_wdata_s != 3'b101) bad++;
        exp_cnt++;
        writes++;
      end
      if (clr_done_s) begin
        done_seen = 1;
        chk("t5_busy_at_done", clr_busy_s, 0);
      end
      step();
    end
    w0_valid = 0; disp_req = 0;
    extra = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (clr_done_s) extra++;
      step();
    end
    chk("t5_done_seen", done_seen, 1);
    chk("t5_writes", writes, 32);
    chk("t5_bad_writes", bad, 0);
    chk("t5_writer_viol", viol, 0);
    chk("t5_extra_done", extra, 0);

    // 6) reset the full-size instance while its clear counter sits at 1000
    do_reset();
    clr_start = 1; clr_color = 3'b101;
    step();
    clr_start = 0;
    @(negedge clk);
    chk("t6_busy", clr_busy, 1);
    for (int k = 0; k < 1000; k++) step();
    @(negedge clk);
    chk("t6_mem_we", mem_we, 1);
    chk("t6_mem_addr", mem_addr, 999);
    chk("t6_mem_wdata", mem_wdata, 5);
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("t6_mem_en_after_rst", mem_en, 0);
    chk("t6_busy_after_rst", clr_busy, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      @(negedge clk);
      chk("t6_no_done", clr_done, 0);
      chk("t6_no_write", mem_en, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
